// File: rtl/voter_session_if.sv
// Ballot/verdict bundle between ballot-entry logic (master) and voter_session (slave).
interface voter_session_if #(
    parameter int ID_W  = 2,
    parameter int CNT_W = 3
);
    logic             start;
    logic             vote_valid;
    logic [ID_W-1:0]  vote_id;
    logic             vote_yes;
    logic             busy;
    logic             done;
    logic [2:0]       result;
    logic [CNT_W-1:0] yes_cnt;
    logic [CNT_W-1:0] no_cnt;
    logic             dup_err;

    modport master (
        output start, vote_valid, vote_id, vote_yes,
        input  busy, done, result, yes_cnt, no_cnt, dup_err
    );

    modport slave (
        input  start, vote_valid, vote_id, vote_yes,
        output busy, done, result, yes_cnt, no_cnt, dup_err
    );
endinterface

// File: rtl/voter_session.sv
// Clocked voting session: one ballot per cycle, duplicate rejection, timeout, one-hot verdict.
// Optional macro VOTER_QUORUM_EN: verdict 3'b000 when fewer than QUORUM ballots were cast.
module voter_session #(
    parameter int N_VOTERS    = 4,
    parameter int ID_W        = 2,
    parameter int CNT_W       = 3,
    parameter int TIMEOUT_CYC = 16,
    parameter int QUORUM      = 3
) (
    input logic            clk,
    input logic            rst,
    voter_session_if.slave bus
);
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [ID_W:0]      ID_LIMIT = (ID_W + 1)'(N_VOTERS);
    localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_DECIDE  = 2'd2;

    if ((2 ** ID_W) < N_VOTERS || TIMEOUT_CYC < 1 || QUORUM < 0 || (2 ** CNT_W) <= N_VOTERS) begin : g_bad_params
        $error("voter_session: illegal parameter combination");
    end

    logic [1:0]          state_q, state_d;
    logic [N_VOTERS-1:0] mask_q, mask_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0]    yes_q, yes_d, no_q, no_d;
    logic [2:0]          result_q, result_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                dup_q, dup_d;
    logic                in_range, accept;
    logic [2:0]          verdict;

`ifdef VOTER_QUORUM_EN
    localparam logic [CNT_W:0] QUORUM_W = (CNT_W + 1)'(QUORUM);
`endif

    always_comb begin
        if (yes_q > no_q)
            verdict = 3'b100;
        else if (yes_q == no_q)
            verdict = 3'b010;
        else
            verdict = 3'b001;
`ifdef VOTER_QUORUM_EN
        if (({1'b0, yes_q} + {1'b0, no_q}) < QUORUM_W)
            verdict = 3'b000;
`endif
    end

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        timer_d  = timer_q;
        yes_d    = yes_q;
        no_d     = no_q;
        result_d = result_q;
        done_d   = 1'b0;
        dup_d    = 1'b0;
        in_range = ({1'b0, bus.vote_id} < ID_LIMIT);
        accept   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_COLLECT;
                    mask_d  = '0;
                    timer_d = '0;
                    yes_d   = '0;
                    no_d    = '0;
                end
            end
            S_COLLECT: begin
                timer_d = timer_q + 1'b1;
                accept  = bus.vote_valid && in_range && !mask_q[bus.vote_id];
                dup_d   = bus.vote_valid && !accept;
                if (accept) begin
                    mask_d[bus.vote_id] = 1'b1;
                    if (bus.vote_yes)
                        yes_d = yes_q + 1'b1;
                    else
                        no_d = no_q + 1'b1;
                end
                // completion looks at the updated mask so the last ballot closes the session at once
                if ((&mask_d) || (timer_q == TMR_LAST))
                    state_d = S_DECIDE;
            end
            S_DECIDE: begin
                result_d = verdict;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mask_q   <= '0;
            timer_q  <= '0;
            yes_q    <= '0;
            no_q     <= '0;
            result_q <= 3'b000;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            dup_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            timer_q  <= timer_d;
            yes_q    <= yes_d;
            no_q     <= no_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            dup_q    <= dup_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.result  = result_q;
    assign bus.yes_cnt = yes_q;
    assign bus.no_cnt  = no_q;
    assign bus.dup_err = dup_q;
endmodule

// File: doc/voter_session.md
Name: voter_session

Overview:
- Parametrised, clocked successor to the 4-input combinational voter.
- Runs a voting session: collects one ballot per cycle from up to N_VOTERS voters and rejects duplicates.
- Closes the session when every voter has voted or a timeout expires, then registers a one-hot pass/tie/fail verdict.
- Sits between ballot-entry logic and the display/result logic.

Parameters:
- N_VOTERS, 4: number of voters; legal ids are 0..N_VOTERS-1.
- ID_W, 2: width of vote_id; must satisfy 2^ID_W >= N_VOTERS.
- CNT_W, 3: width of the tally counters; must hold the value N_VOTERS.
- TIMEOUT_CYC, 16: maximum number of cycles spent in COLLECT (>=1).
- QUORUM, 3: minimum ballots cast; used only when VOTER_QUORUM_EN is defined.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  opens a session; sampled in IDLE only.
- vote_valid  input  1  ballot present this cycle.
- vote_id  input  ID_W  voter identity.
- vote_yes  input  1  1 = yes, 0 = no.
- busy  output  1  high while in COLLECT or DECIDE.
- done  output  1  one-cycle pulse when result updates.
- result  output  3  one-hot verdict {pass, tie, fail}; bit 2 = pass, bit 1 = tie, bit 0 = fail.
- yes_cnt  output  CNT_W  live yes tally.
- no_cnt  output  CNT_W  live no tally.
- dup_err  output  1  one-cycle pulse for a rejected ballot.

Behaviour:
- Reset (async, any state): state=IDLE; mask, timer, yes_cnt, no_cnt = 0; result=3'b000; done, busy, dup_err = 0. Reset mid-session aborts the session with no done pulse.
- All outputs are registered.
- States: IDLE, COLLECT, DECIDE.
- IDLE:
  - busy=0.
  - start=1 -> COLLECT at the next edge; on that edge clear mask, timer, yes_cnt and no_cnt.
  - result holds its previous value until the next DECIDE.
  - vote_valid in IDLE is ignored, with no dup_err.
- COLLECT:
  - busy=1; timer increments every cycle; start is ignored.
  - Ballot accepted when vote_valid=1, vote_id<N_VOTERS and mask[vote_id]=0. On acceptance, set mask[vote_id] and increment yes_cnt or no_cnt per vote_yes.
  - vote_valid=1 with vote_id>=N_VOTERS or mask[vote_id]=1: ballot dropped, dup_err=1 for the following cycle, tallies unchanged.
  - Exit to DECIDE when the mask becomes all-ones (checked including the ballot accepted this cycle) or when timer==TIMEOUT_CYC-1.
  - A ballot presented on the timeout cycle is still accepted.
  - Simultaneous completion and timeout -> DECIDE (single transition).
- DECIDE:
  - Exactly one cycle; busy=1.
  - At its closing edge: result = 3'b100 if yes_cnt>no_cnt, 3'b010 if equal, 3'b001 if yes_cnt<no_cnt. Non-voters count as abstentions.
  - done=1 for exactly one cycle; state -> IDLE.
- Latency: the completing ballot presented in cycle t gives done=1 and the new result in cycle t+2.
- Zero ballots cast gives a tie (3'b010).
- start may be asserted in the cycle done is high; a new session then begins normally.

Optional Feature:
- Macro VOTER_QUORUM_EN.
- Defined:
  - In DECIDE, if yes_cnt+no_cnt < QUORUM, result=3'b000 (no quorum); done still pulses.
  - Otherwise the normal verdict applies.
  - The sum is computed CNT_W+1 bits wide to avoid overflow.
- Not defined:
  - QUORUM is ignored and no quorum logic is synthesised.
  - result is always one-hot after the first session.

Test Plan:
1. Defaults. start, then ballots id0 yes, id1 yes, id2 no, id3 yes on consecutive cycles -> yes_cnt=3, no_cnt=1, result=3'b100, done pulse 2 cycles after the id3 ballot, busy low the cycle after done.
2. id0 yes, id1 no, id2 yes, id3 no -> result=3'b010. Then id0 no, id1 no, id2 no, id3 yes -> result=3'b001. No start needed between sessions beyond one start pulse each.
3. Duplicate and range: id1 yes, id1 no -> second ballot dropped, dup_err pulse, yes_cnt=1, no_cnt=0. With N_VOTERS=3, ID_W=2: id3 -> dup_err pulse.
4. Timeout: only id0 no, then idle -> DECIDE after exactly 16 COLLECT cycles, result=3'b001. With no ballots at all -> 3'b010.
5. Quorum (VOTER_QUORUM_EN, QUORUM=3): 2 yes then timeout -> result=3'b000 with done pulse. 3 yes -> 3'b100.
6. Reset: assert rst mid-COLLECT after 2 ballots -> all outputs 0 immediately, no done. A new start then runs a clean session with tallies starting from 0.
